round_key_gen: RTL and testbench

- Iterative AES-128 key expansion stage that sits directly upstream of the cipher round pipeline and drives its i_round_key input.
- It accepts one 128-bit cipher key and streams round keys 0..NUM_ROUNDS in order, one per cycle, under a valid/ready handshake.
- It computes each round key from the previous one in a single register stage.
- The downstream pipeline consumes round key 0 first; no key RAM is required.

---
 rtl/round_key_gen_pkg.sv | 43 ++++
 rtl/round_key_gen_key_g_word.sv | 26 ++
 rtl/round_key_gen.sv | 117 +++++++++++
 tb/tb_round_key_gen.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/round_key_gen_pkg.sv
`default_nettype none
// ============================================================================
// round_key_gen_pkg : shared types, AES S-box and rcon helpers for key expansion
// Revision 1.0
// ============================================================================
package round_key_gen_pkg;

  typedef logic [127:0] block_t;
  typedef logic [31:0]  word_t;

  localparam int          NUM_ROUNDS_AES128 = 10;
  localparam logic [7:0]  RCON_INIT         = 8'h01;

  // Byte 0x00 sits in the top byte so a row reads left to right like the FIPS table.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] aes_sbox(input logic [7:0] x);
    return SBOX_TABLE[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/round_key_gen_key_g_word.sv
`default_nettype none
// ============================================================================
// key_g_word : AES-128 key schedule g() : SubWord(RotWord(w3)) ^ {rcon, 24'h0}
// Revision 1.0
// ============================================================================
module key_g_word
  import round_key_gen_pkg::*;
(
  input  logic [31:0] i_w3,
  input  logic [7:0]  i_rcon,
  output logic [31:0] o_t
);

  logic [31:0] rot_w;
  logic [31:0] sub_w;

  assign rot_w = {i_w3[23:0], i_w3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sub
    assign sub_w[8*i +: 8] = aes_sbox(rot_w[8*i +: 8]);
  end

  assign o_t = sub_w ^ {i_rcon, 24'h000000};

endmodule
`default_nettype wire

// File: rtl/round_key_gen.sv
`default_nettype none
// ============================================================================
// round_key_gen : iterative AES-128 key expansion, one round key per handshake
// Revision 1.0
// ============================================================================
module round_key_gen
  import round_key_gen_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_AES128
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_key_valid,
  input  logic [127:0] i_key,
  output logic         o_key_ready,
  output logic         o_rk_valid,
  output logic [127:0] o_rk,
  output logic [3:0]   o_rk_idx,
  output logic         o_rk_last,
  input  logic         i_rk_ready
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  state_t     state_q, state_d;
  block_t     rk_q, rk_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] rcon_q, rcon_d;
  logic       valid_q, valid_d;
  logic       last_q, last_d;

  word_t  t_w;
  word_t  w0_n, w1_n, w2_n, w3_n;
  logic   fire_w;

  key_g_word u_g (
    .i_w3   (rk_q[31:0]),
    .i_rcon (rcon_q),
    .o_t    (t_w)
  );

  // Each new word folds in the freshly computed word to its left.
  assign w0_n   = rk_q[127:96] ^ t_w;
  assign w1_n   = rk_q[95:64]  ^ w0_n;
  assign w2_n   = rk_q[63:32]  ^ w1_n;
  assign w3_n   = rk_q[31:0]   ^ w2_n;
  assign fire_w = valid_q & i_rk_ready;

  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    idx_d   = idx_q;
    rcon_d  = rcon_q;
    valid_d = valid_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (i_key_valid) begin
          rk_d    = i_key;
          idx_d   = 4'd0;
          rcon_d  = RCON_INIT;
          valid_d = 1'b1;
          last_d  = 1'b0;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (fire_w) begin
          if (idx_q == LAST_IDX) begin
            rk_d    = '0;
            idx_d   = 4'd0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            rk_d    = {w0_n, w1_n, w2_n, w3_n};
            idx_d   = idx_q + 4'd1;
            rcon_d  = xtime(rcon_q);
            last_d  = ((idx_q + 4'd1) == LAST_IDX);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      rk_q    <= '0;
      idx_q   <= 4'd0;
      rcon_q  <= RCON_INIT;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      idx_q   <= idx_d;
      rcon_q  <= rcon_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign o_key_ready = (state_q == ST_IDLE);
  assign o_rk_valid  = valid_q;
  assign o_rk        = rk_q;
  assign o_rk_idx    = idx_q;
  assign o_rk_last   = last_q;

endmodule
`default_nettype wire

// File: tb/tb_round_key_gen.sv
`default_nettype none
// ============================================================================
// tb_round_key_gen : self-checking bench, GF(2^8)-derived reference key schedule
// Revision 1.0
// ============================================================================
module tb_round_key_gen;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic         a_key_valid = 1'b0, a_key_ready, a_rk_valid, a_rk_last, a_rk_ready = 1'b0;
  logic [127:0] a_key = '0, a_rk;
  logic [3:0]   a_rk_idx;
  logic         b_key_valid = 1'b0, b_key_ready, b_rk_valid, b_rk_last, b_rk_ready = 1'b0;
  logic [127:0] b_key = '0, b_rk;
  logic [3:0]   b_rk_idx;

  round_key_gen u_dut_a (
    .clock(clock), .reset(reset), .i_key_valid(a_key_valid), .i_key(a_key),
    .o_key_ready(a_key_ready), .o_rk_valid(a_rk_valid), .o_rk(a_rk),
    .o_rk_idx(a_rk_idx), .o_rk_last(a_rk_last), .i_rk_ready(a_rk_ready)
  );

  round_key_gen #(.NUM_ROUNDS(4)) u_dut_b (
    .clock(clock), .reset(reset), .i_key_valid(b_key_valid), .i_key(b_key),
    .o_key_ready(b_key_ready), .o_rk_valid(b_rk_valid), .o_rk(b_rk),
    .o_rk_idx(b_rk_idx), .o_rk_last(b_rk_last), .i_rk_ready(b_rk_ready)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]   sbox_m [256];
  logic [7:0]   rcon_m [1:10];
  logic [127:0] ref_k  [0:10];
  logic [127:0] got    [0:10];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Polynomial product reduced modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= (16'(a) << i);
    for (int k = 15; k >= 8; k--) if (p[k]) p ^= (16'h011b << (k - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  task automatic build_tables();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    rcon_m[1] = 8'h01;
    for (int r = 2; r <= 10; r++) rcon_m[r] = gmul(rcon_m[r-1], 8'h02);
  endtask

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      logic [31:0] t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
        t ^= {rcon_m[i/4], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) ref_k[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0, 2: random ready,
  // 3: always ready with an all-zero key held on i_key_valid throughout.
  task automatic run_key(input logic [127:0] key, input int mode);
    int  e = 0;
    int  cyc = 0;
    logic rdy;
    logic done = 1'b0;
    model_expand(key);
    while (!a_key_ready && cyc < 20) begin @(negedge clock); cyc++; end
    chk("key_ready_idle", a_key_ready, 1);
    a_key_valid = 1'b1;
    a_key = key;
    @(negedge clock);
    if (mode == 3) a_key = '0;
    else a_key_valid = 1'b0;
    cyc = 0;
    while (!done && cyc < 200) begin
      chk("rk_valid", a_rk_valid, 1);
      chk("key_ready_busy", a_key_ready, 0);
      chk("rk_idx", a_rk_idx, e);
      chk("rk", a_rk, ref_k[e]);
      chk("rk_last", a_rk_last, (e == 10));
      case (mode)
        1:       rdy = (cyc % 3 == 0);
        2:       rdy = 1'($urandom_range(0, 1));
        default: rdy = 1'b1;
      endcase
      a_rk_ready = rdy;
      if (rdy) begin
        got[e] = a_rk;
        if (e == 10) done = 1'b1;
        else e++;
      end
      @(negedge clock);
      cyc++;
    end
    if (!done) chk("stream_timeout", 0, 1);
    a_rk_ready = 1'b0;
    chk("bubble_valid", a_rk_valid, 0);
    chk("bubble_key_ready", a_key_ready, 1);
    chk("bubble_rk", a_rk, 0);
    chk("bubble_idx", a_rk_idx, 0);
  endtask

  typedef struct {
    logic [127:0] key;
    int           idx;
    logic [127:0] exp;
  } vec_t;

  initial begin
    vec_t tbl [5];
    int   cyc;
    tbl[0] = '{FIPS_KEY, 0,  FIPS_KEY};
    tbl[1] = '{FIPS_KEY, 1,  FIPS_R1};
    tbl[2] = '{FIPS_KEY, 10, FIPS_R10};
    tbl[3] = '{128'h0,   1,  ZERO_R1};
    tbl[4] = '{128'h0,   10, ZERO_R10};

    build_tables();
    #1 reset = 1'b0;
    #2;
    chk("rst_key_ready", a_key_ready, 1);
    chk("rst_rk_valid", a_rk_valid, 0);
    chk("rst_rk", a_rk, 0);
    chk("rst_idx", a_rk_idx, 0);
    chk("rst_last", a_rk_last, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Fixed FIPS-197 and all-zero expectations.
    foreach (tbl[i]) begin
      run_key(tbl[i].key, 0);
      chk("table", got[tbl[i].idx], tbl[i].exp);
    end

    // Backpressure: same sequence under stalls.
    run_key(FIPS_KEY, 1);
    chk("bp_idx1", got[1], FIPS_R1);
    chk("bp_idx10", got[10], FIPS_R10);

    // Busy rejection, then acceptance in the cycle after the bubble.
    run_key(FIPS_KEY, 3);
    chk("busy_idx10", got[10], FIPS_R10);
    @(negedge clock);
    a_key_valid = 1'b0;
    chk("busy_accept_valid", a_rk_valid, 1);
    chk("busy_accept_rk", a_rk, 0);
    chk("busy_accept_idx", a_rk_idx, 0);
    model_expand(128'h0);
    a_rk_ready = 1'b1;
    for (int e = 0; e <= 10; e++) begin
      chk("busy_drain_rk", a_rk, ref_k[e]);
      @(negedge clock);
    end
    a_rk_ready = 1'b0;
    chk("busy_drain_end", a_rk_valid, 0);

    // Random keys with random backpressure.
    for (int n = 0; n < 6; n++)
      run_key({$urandom, $urandom, $urandom, $urandom}, 2);

    // Asynchronous reset in the middle of a stream.
    a_key_valid = 1'b1;
    a_key = FIPS_KEY;
    @(negedge clock);
    a_key_valid = 1'b0;
    a_rk_ready = 1'b1;
    cyc = 0;
    while (a_rk_idx != 4'd4 && cyc < 20) begin @(negedge clock); cyc++; end
    chk("mid_reach_idx4", a_rk_idx, 4);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_valid", a_rk_valid, 0);
    chk("mid_rst_rk", a_rk, 0);
    chk("mid_rst_idx", a_rk_idx, 0);
    chk("mid_rst_last", a_rk_last, 0);
    chk("mid_rst_key_ready", a_key_ready, 1);
    @(negedge clock);
    reset = 1'b1;
    a_rk_ready = 1'b0;
    @(negedge clock);
    run_key(FIPS_KEY, 0);
    chk("post_rst_idx1", got[1], FIPS_R1);

    // NUM_ROUNDS = 4 instance.
    model_expand(FIPS_KEY);
    b_key_valid = 1'b1;
    b_key = FIPS_KEY;
    @(negedge clock);
    b_key_valid = 1'b0;
    b_rk_ready = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      chk("nr4_valid", b_rk_valid, 1);
      chk("nr4_idx", b_rk_idx, i);
      chk("nr4_rk", b_rk, ref_k[i]);
      chk("nr4_last", b_rk_last, (i == 4));
      @(negedge clock);
    end
    b_rk_ready = 1'b0;
    chk("nr4_end_valid", b_rk_valid, 0);
    chk("nr4_end_key_ready", b_key_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
